sha2_compress_core: RTL and testbench

- Parametrised SHA-2 compression engine: one round per clock, plus the intermediate-hash register and multi-block chaining.
- Supports SHA-256 (WORD_SIZE=32, ROUNDS=64) and SHA-512 (WORD_SIZE=64, ROUNDS=80).
- Sits between the message-schedule unit and the digest consumer.
- Round index is driven out; the schedule word W[t] and round constant K[t] come back combinationally in the same cycle from external schedule/ROM logic.

---
 rtl/sha2_compress_core_if.sv | 66 ++++++
 rtl/sha2_compress_core.sv | 221 ++++++++++++++++++++++
 tb/tb_sha2_compress_core.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha2_compress_core_if.sv
// rtl/sha2_compress_core_if.sv - handshake, schedule-feed and digest bundle for sha2_compress_core
//
// Purpose: groups every non-clock/reset signal of the compression core so the
// schedule unit / digest consumer side and the core side connect through one port.
//
// Signals (direction as seen from the core, i.e. the slave modport):
//   clear                   in   synchronous abort back to IDLE
//   block_valid             in   a new block's schedule is available
//   block_ready             out  high only while the core is IDLE
//   first_block             in   1: start from init_value, 0: chain from H
//   init_value              in   IV, word a at the MSBs
//   round_index             out  current round t
//   message_schedule_value  in   W[t] for round_index (combinational return)
//   round_constant          in   K[t] for round_index (combinational return)
//   H                       out  intermediate/final hash, word a at the MSBs
//   digest_valid            out  one-cycle pulse after each completed block
//   busy                    out  high while rounds or the final update run

interface sha2_compress_core_if #(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS    = 64
);
  localparam int IDX_W = $clog2(ROUNDS);

  logic                   clear;
  logic                   block_valid;
  logic                   block_ready;
  logic                   first_block;
  logic [WORD_SIZE*8-1:0] init_value;
  logic [IDX_W-1:0]       round_index;
  logic [WORD_SIZE-1:0]   message_schedule_value;
  logic [WORD_SIZE-1:0]   round_constant;
  logic [WORD_SIZE*8-1:0] H;
  logic                   digest_valid;
  logic                   busy;

  // Schedule unit / digest consumer side.
  modport master (
    output clear,
    output block_valid,
    output first_block,
    output init_value,
    output message_schedule_value,
    output round_constant,
    input  block_ready,
    input  round_index,
    input  H,
    input  digest_valid,
    input  busy
  );

  // Compression core side.
  modport slave (
    input  clear,
    input  block_valid,
    input  first_block,
    input  init_value,
    input  message_schedule_value,
    input  round_constant,
    output block_ready,
    output round_index,
    output H,
    output digest_valid,
    output busy
  );
endinterface

// File: rtl/sha2_compress_core.sv
// rtl/sha2_compress_core.sv - SHA-2 compression engine, one round per clock with hash chaining
//
// Purpose: runs the SHA-256 (WORD_SIZE=32, ROUNDS=64) or SHA-512 (WORD_SIZE=64,
// ROUNDS=80) compression function over one block per pass. The round index is
// driven out and W[t]/K[t] come back combinationally in the same cycle. After
// the last round the working variables are folded into H and digest_valid
// pulses for one cycle.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   bus    sha2_compress_core_if.slave: clear, block_valid/block_ready,
//          first_block, init_value, round_index, message_schedule_value,
//          round_constant, H, digest_valid, busy

module sha2_compress_core #(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  sha2_compress_core_if.slave  bus
);

  localparam int               IDX_W      = $clog2(ROUNDS);
  localparam int               HASH_W     = WORD_SIZE * 8;
  localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);

  // Only the two standard SHA-2 word/round pairings are meaningful.
  generate
    if (!((WORD_SIZE == 32 && ROUNDS == 64) || (WORD_SIZE == 64 && ROUNDS == 80))) begin : g_bad_params
      $error("sha2_compress_core: WORD_SIZE/ROUNDS must be 32/64 or 64/80");
    end
  endgenerate

  // Big-sigma rotate amounts for the selected variant.
  localparam int S0_R0 = (WORD_SIZE == 64) ? 28 : 2;
  localparam int S0_R1 = (WORD_SIZE == 64) ? 34 : 13;
  localparam int S0_R2 = (WORD_SIZE == 64) ? 39 : 22;
  localparam int S1_R0 = (WORD_SIZE == 64) ? 14 : 6;
  localparam int S1_R1 = (WORD_SIZE == 64) ? 18 : 11;
  localparam int S1_R2 = (WORD_SIZE == 64) ? 41 : 25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working variables a..h.
  logic [WORD_SIZE-1:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;

  logic [HASH_W-1:0]    hash_q;
  logic [HASH_W-1:0]    hash_sum;
  logic [HASH_W-1:0]    work_vec;
  logic [HASH_W-1:0]    load_vec;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_next;
  logic                 dv_q;
  logic                 dv_next;

  logic                 load_work;
  logic                 load_iv;
  logic                 do_round;
  logic                 do_update;
  logic                 ready_int;
  logic                 busy_int;

  logic [WORD_SIZE-1:0] sum0, sum1, ch, maj, t1, t2;

  function automatic logic [WORD_SIZE-1:0] rotr(input logic [WORD_SIZE-1:0] x, input int n);
    rotr = (x >> n) | (x << (WORD_SIZE - n));
  endfunction

  // ------------------------------------------------------------------
  // Round datapath (combinational, consumes this cycle's W and K)
  // ------------------------------------------------------------------
  assign sum0 = rotr(a_q, S0_R0) ^ rotr(a_q, S0_R1) ^ rotr(a_q, S0_R2);
  assign sum1 = rotr(e_q, S1_R0) ^ rotr(e_q, S1_R1) ^ rotr(e_q, S1_R2);
  assign ch   = (e_q & f_q) ^ (~e_q & g_q);
  assign maj  = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
  assign t1   = h_q + sum1 + ch + bus.round_constant + bus.message_schedule_value;
  assign t2   = sum0 + maj;

  assign work_vec = {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};

  // first_block picks the starting point: a fresh IV or the running hash.
  assign load_vec = bus.first_block ? bus.init_value : hash_q;

  // Per-word addition; each lane wraps on its own, no carry into the next word.
  always_comb begin
    hash_sum = '0;
    for (int i = 0; i < 8; i++) begin
      hash_sum[i*WORD_SIZE +: WORD_SIZE] = hash_q[i*WORD_SIZE +: WORD_SIZE]
                                         + work_vec[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    dv_next    = 1'b0;
    load_work  = 1'b0;
    load_iv    = 1'b0;
    do_round   = 1'b0;
    do_update  = 1'b0;
    ready_int  = 1'b0;
    busy_int   = 1'b0;

    case (state)
      ST_IDLE: begin
        ready_int = 1'b1;
        idx_next  = '0;
        if (bus.block_valid) begin
          load_work  = 1'b1;
          load_iv    = bus.first_block;
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        busy_int = 1'b1;
        do_round = 1'b1;
        if (idx_q == LAST_ROUND) begin
          idx_next   = '0;
          state_next = ST_UPDATE;
        end else begin
          idx_next = idx_q + IDX_W'(1);
        end
      end
      ST_UPDATE: begin
        busy_int   = 1'b1;
        do_update  = 1'b1;
        dv_next    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a pending accept and the final
    // hash update, so H keeps the last completed digest.
    if (bus.clear) begin
      state_next = ST_IDLE;
      idx_next   = '0;
      dv_next    = 1'b0;
      load_work  = 1'b0;
      load_iv    = 1'b0;
      do_round   = 1'b0;
      do_update  = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      e_q <= '0;
      f_q <= '0;
      g_q <= '0;
      h_q <= '0;
    end else if (load_work) begin
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= load_vec;
    end else if (do_round) begin
      h_q <= g_q;
      g_q <= f_q;
      f_q <= e_q;
      e_q <= d_q + t1;
      d_q <= c_q;
      c_q <= b_q;
      b_q <= a_q;
      a_q <= t1 + t2;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hash_q <= '0;
    end else if (load_iv) begin
      hash_q <= bus.init_value;
    end else if (do_update) begin
      hash_q <= hash_sum;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      idx_q <= idx_next;
      dv_q  <= dv_next;
    end
  end

  assign bus.block_ready  = ready_int;
  assign bus.busy         = busy_int;
  assign bus.round_index  = idx_q;
  assign bus.H            = hash_q;
  assign bus.digest_valid = dv_q;

endmodule

// File: tb/tb_sha2_compress_core.sv
// tb/tb_sha2_compress_core.sv - self-checking bench for sha2_compress_core (SHA-256 and SHA-512 instances)

module tb_sha2_compress_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  sha2_compress_core_if #(.WORD_SIZE(32), .ROUNDS(64)) b32 ();
  sha2_compress_core_if #(.WORD_SIZE(64), .ROUNDS(80)) b64 ();

  sha2_compress_core #(.WORD_SIZE(32), .ROUNDS(64)) u32 (.clock(clk), .reset(rst_n), .bus(b32));
  sha2_compress_core #(.WORD_SIZE(64), .ROUNDS(80)) u64 (.clock(clk), .reset(rst_n), .bus(b64));

  // SHA-512 round constants; SHA-256 constants are the upper 32 bits of the first 64.
  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DIG_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_2BLK = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] IV512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
    64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] DIG_ABC512 = {64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2,
    64'h0a9eeee64b55d39a, 64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  // Schedule ROM models feeding W[t]/K[t] back in the same cycle.
  logic [31:0] w32 [64];
  logic [63:0] w64 [80];
  assign b32.message_schedule_value = w32[b32.round_index];
  assign b32.round_constant         = K512[b32.round_index][63:32];
  assign b64.message_schedule_value = w64[b64.round_index];
  assign b64.round_constant         = K512[b64.round_index];

  // Reference model state: current block words, expanded schedule, running hash.
  logic [63:0] blk [16];
  logic [63:0] sched [80];
  logic [63:0] mh [8];
  bit          seq_ok;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] msk(input logic [63:0] x, input bit wide);
    return wide ? x : (x & 64'h0000_0000_ffff_ffff);
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit wide);
    if (wide) return (x >> n) | (x << (64 - n));
    return msk((x >> n) | (x << (32 - n)), 1'b0);
  endfunction

  function automatic logic [63:0] big_s0(input logic [63:0] x, input bit wide);
    return wide ? rotr(x, 28, 1) ^ rotr(x, 34, 1) ^ rotr(x, 39, 1)
                : rotr(x, 2, 0) ^ rotr(x, 13, 0) ^ rotr(x, 22, 0);
  endfunction

  function automatic logic [63:0] big_s1(input logic [63:0] x, input bit wide);
    return wide ? rotr(x, 14, 1) ^ rotr(x, 18, 1) ^ rotr(x, 41, 1)
                : rotr(x, 6, 0) ^ rotr(x, 11, 0) ^ rotr(x, 25, 0);
  endfunction

  function automatic logic [63:0] sml_s0(input logic [63:0] x, input bit wide);
    return wide ? rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7)
                : rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] sml_s1(input logic [63:0] x, input bit wide);
    return wide ? rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6)
                : rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ (x >> 10);
  endfunction

  // Standard padding of a short message; fills blk with block number bn.
  task automatic pad_block(input string s, input int bn, input bit wide);
    int          bb = wide ? 128 : 64;
    int          wb = wide ? 8 : 4;
    int          len = s.len();
    int          nb  = (len + 1 + (wide ? 16 : 8) + bb - 1) / bb;
    int          tot = nb * bb;
    logic [63:0] bitlen = 64'(len) * 64'd8;
    for (int j = 0; j < 16; j++) begin
      logic [63:0] w = '0;
      for (int k = 0; k < wb; k++) begin
        int         p = bn * bb + j * wb + k;
        logic [7:0] bv;
        if (p < len)            bv = s[p];
        else if (p == len)      bv = 8'h80;
        else if (p >= tot - 8)  bv = 8'(bitlen >> (8 * (tot - 1 - p)));
        else                    bv = 8'h00;
        w = (w << 8) | 64'(bv);
      end
      blk[j] = w;
    end
  endtask

  task automatic random_block(input bit wide);
    for (int j = 0; j < 16; j++) blk[j] = wide ? {$urandom, $urandom} : {32'h0, $urandom};
  endtask

  // Expand blk into the schedule and publish it to the ROM models.
  task automatic expand(input bit wide);
    int rounds = wide ? 80 : 64;
    for (int t = 0; t < 80; t++) sched[t] = '0;
    for (int t = 0; t < 16; t++) sched[t] = blk[t];
    for (int t = 16; t < rounds; t++)
      sched[t] = msk(sml_s1(sched[t-2], wide) + sched[t-7] + sml_s0(sched[t-15], wide) + sched[t-16], wide);
    for (int t = 0; t < 64; t++) w32[t] = sched[t][31:0];
    for (int t = 0; t < 80; t++) w64[t] = sched[t];
  endtask

  task automatic set_iv(input bit wide, input logic [511:0] iv);
    for (int i = 0; i < 8; i++) mh[i] = wide ? iv[511-64*i -: 64] : {32'h0, iv[255-32*i -: 32]};
  endtask

  // Reference SHA-2 compression of the expanded schedule into mh.
  task automatic model_block(input bit wide);
    logic [63:0] v [8];
    logic [63:0] t1, t2, kt;
    int          rounds = wide ? 80 : 64;
    for (int i = 0; i < 8; i++) v[i] = mh[i];
    for (int t = 0; t < rounds; t++) begin
      kt = wide ? K512[t] : {32'h0, K512[t][63:32]};
      t1 = msk(v[7] + big_s1(v[4], wide) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt + sched[t], wide);
      t2 = msk(big_s0(v[0], wide) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2])), wide);
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = msk(v[3] + t1, wide);
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = msk(t1 + t2, wide);
    end
    for (int i = 0; i < 8; i++) mh[i] = msk(mh[i] + v[i], wide);
  endtask

  function automatic logic [511:0] pack(input bit wide);
    logic [511:0] r = '0;
    for (int i = 0; i < 8; i++) r = (r << (wide ? 64 : 32)) | 512'(mh[i]);
    return r;
  endfunction

  function automatic logic [511:0] h_of(input bit wide);
    return wide ? b64.H : {256'h0, b32.H};
  endfunction

  function automatic bit dv_of(input bit wide);
    return wide ? b64.digest_valid : b32.digest_valid;
  endfunction

  function automatic int idx_of(input bit wide);
    return wide ? int'(b64.round_index) : int'(b32.round_index);
  endfunction

  function automatic bit busy_of(input bit wide);
    return wide ? b64.busy : b32.busy;
  endfunction

  function automatic bit rdy_of(input bit wide);
    return wide ? b64.block_ready : b32.block_ready;
  endfunction

  // Offers one block, then follows it to digest_valid; lat counts edges after
  // the accepting edge. Called #1 after an edge with the core idle.
  task automatic run_block(input bit wide, input bit first, input logic [511:0] iv, input bit hold, output int lat);
    int rounds = wide ? 80 : 64;
    if (wide) begin
      b64.first_block = first; b64.init_value = iv; b64.block_valid = 1'b1;
    end else begin
      b32.first_block = first; b32.init_value = iv[255:0]; b32.block_valid = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) begin b32.block_valid = 1'b0; b64.block_valid = 1'b0; end
    lat = 0;
    seq_ok = 1'b1;
    while (!dv_of(wide) && lat < 200) begin
      if (idx_of(wide) != ((lat < rounds) ? lat : 0) || !busy_of(wide) || rdy_of(wide)) seq_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    b32.block_valid = 1'b0;
    b64.block_valid = 1'b0;
  endtask

  task automatic wait_idx32(input int target);
    int n = 0;
    while (int'(b32.round_index) != target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_round", 512'(b32.round_index), 512'(target));
  endtask

  initial begin
    int           lat;
    int           c1;
    bit           saw;
    logic [511:0] hexp;
    logic [511:0] iv;
    string        msg2 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

    rst_n = 1'b0;
    b32.clear = 0; b32.block_valid = 0; b32.first_block = 0; b32.init_value = '0;
    b64.clear = 0; b64.block_valid = 0; b64.first_block = 0; b64.init_value = '0;
    for (int t = 0; t < 64; t++) w32[t] = '0;
    for (int t = 0; t < 80; t++) w64[t] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_h32", h_of(0), '0);
    check("rst_h64", h_of(1), '0);
    check("rst_dv", 512'({b32.digest_valid, b64.digest_valid}), '0);
    check("rst_idx", 512'(b32.round_index), '0);
    check("rst_ready", 512'({b32.block_ready, b64.block_ready, b32.busy}), 512'(3'b110));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SHA-256 "abc"
    pad_block("abc", 0, 0); expand(0); set_iv(0, IV256); model_block(0);
    run_block(0, 1, 512'(IV256), 0, lat);
    check("abc256_lat", 512'(lat), 512'(65));
    check("abc256_seq", 512'(seq_ok), 512'(1));
    check("abc256_h", h_of(0), 512'(DIG_ABC256));

    // Two-block message, second block accepted in the digest_valid cycle
    pad_block(msg2, 0, 0); expand(0); set_iv(0, IV256); model_block(0);
    run_block(0, 1, 512'(IV256), 0, lat);
    c1 = cyc;
    check("blk1_h", h_of(0), pack(0));
    pad_block(msg2, 1, 0); expand(0); model_block(0);
    run_block(0, 0, '0, 0, lat);
    check("blk2_lat", 512'(lat), 512'(65));
    check("pulse_gap", 512'(cyc - c1), 512'(66));
    check("blk2_h", h_of(0), 512'(DIG_2BLK));

    // block_valid held high for the whole block
    pad_block("abc", 0, 0); expand(0); set_iv(0, IV256); model_block(0);
    run_block(0, 1, 512'(IV256), 1, lat);
    check("hold_seq", 512'(seq_ok), 512'(1));
    check("hold_lat", 512'(lat), 512'(65));
    check("hold_h", h_of(0), 512'(DIG_ABC256));

    // clear at round 30 of a chained block
    pad_block(msg2, 0, 0); expand(0); set_iv(0, IV256); model_block(0);
    run_block(0, 1, 512'(IV256), 0, lat);
    hexp = pack(0);
    pad_block(msg2, 1, 0); expand(0);
    b32.first_block = 0; b32.block_valid = 1;
    @(posedge clk); #1;
    b32.block_valid = 0;
    wait_idx32(30);
    b32.clear = 1;
    @(posedge clk); #1;
    b32.clear = 0;
    check("clr_ready", 512'({b32.block_ready, b32.busy}), 512'(2'b10));
    check("clr_idx", 512'(b32.round_index), '0);
    check("clr_h", h_of(0), hexp);
    saw = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (b32.digest_valid) saw = 1;
    end
    check("clr_no_dv", 512'(saw), '0);
    model_block(0);
    run_block(0, 0, '0, 0, lat);
    check("clr_rerun_h", h_of(0), 512'(DIG_2BLK));

    // clear landing on the UPDATE edge drops the update
    b32.first_block = 0; b32.block_valid = 1;
    @(posedge clk); #1;
    b32.block_valid = 0;
    repeat (64) @(posedge clk);
    #1;
    check("upd_state", 512'({b32.busy, b32.digest_valid}), 512'(2'b10));
    b32.clear = 1;
    @(posedge clk); #1;
    b32.clear = 0;
    check("upd_clr_h", h_of(0), 512'(DIG_2BLK));
    check("upd_clr_dv", 512'({b32.digest_valid, b32.block_ready}), 512'(2'b01));

    // clear beats block_valid in IDLE
    b32.clear = 1; b32.block_valid = 1; b32.first_block = 1;
    b32.init_value = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    b32.clear = 0; b32.block_valid = 0;
    check("clr_vs_valid", 512'({b32.block_ready, b32.busy}), 512'(2'b10));
    check("clr_vs_valid_h", h_of(0), 512'(DIG_2BLK));

    // asynchronous reset at round 40
    pad_block("abc", 0, 0); expand(0);
    b32.first_block = 1; b32.init_value = IV256; b32.block_valid = 1;
    @(posedge clk); #1;
    b32.block_valid = 0;
    wait_idx32(40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_h", h_of(0), '0);
    check("arst_dv_idx", 512'({b32.digest_valid, b32.round_index}), '0);
    check("arst_ready", 512'(b32.block_ready), 512'(1));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    set_iv(0, IV256); model_block(0);
    run_block(0, 1, 512'(IV256), 0, lat);
    check("arst_rerun_h", h_of(0), 512'(DIG_ABC256));

    // random chained SHA-256 blocks, back to back
    iv = 512'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    set_iv(0, iv);
    for (int b = 0; b < 3; b++) begin
      random_block(0); expand(0); model_block(0);
      run_block(0, b == 0, iv, 0, lat);
      check("rnd32_lat", 512'(lat), 512'(65));
      check("rnd32_h", h_of(0), pack(0));
    end

    // SHA-512 "abc"
    pad_block("abc", 0, 1); expand(1); set_iv(1, IV512); model_block(1);
    run_block(1, 1, IV512, 0, lat);
    check("abc512_lat", 512'(lat), 512'(81));
    check("abc512_seq", 512'(seq_ok), 512'(1));
    check("abc512_h", h_of(1), DIG_ABC512);

    // random SHA-512 blocks chained from the "abc" state
    for (int b = 0; b < 2; b++) begin
      random_block(1); expand(1); model_block(1);
      run_block(1, 0, '0, 0, lat);
      check("rnd64_lat", 512'(lat), 512'(81));
      check("rnd64_h", h_of(1), pack(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
